// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pkg
// Description : Shared types and constants for the instruction-fetch stage.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

    // Canonical RISC-V NOP (addi x0, x0, 0) presented to decode when empty
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // Fetch sequencer states
    typedef enum logic [1:0] {
        IDLE = 2'd0,   // no request outstanding
        REQ  = 2'd1,   // request outstanding, data will be kept
        DROP = 2'd2    // request outstanding, data will be discarded
    } fetch_state_t;

    // One prefetch buffer entry
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/fetch_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit_if
// Description : Instruction-memory, redirect and decode-side signals of the
//               fetch stage. fetch_misalign exists only when
//               FETCH_MISALIGN_TRAP_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
interface fetch_unit_if;
    import fetch_pkg::*;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        pc_sel;
    logic [31:0] target_pc;
    logic        stall;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic        fetch_misalign;
`endif

    // Fetch-unit side
    modport master (
`ifdef FETCH_MISALIGN_TRAP_EN
        output fetch_misalign,
`endif
        output imem_req, imem_addr, instr, instr_pc, instr_valid,
        input  imem_ack, imem_rdata, pc_sel, target_pc, stall
    );

    // Memory / pipeline environment side
    modport slave (
`ifdef FETCH_MISALIGN_TRAP_EN
        input  fetch_misalign,
`endif
        input  imem_req, imem_addr, instr, instr_pc, instr_valid,
        output imem_ack, imem_rdata, pc_sel, target_pc, stall
    );

endinterface
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module      : fetch_fifo
// Description : Small synchronous prefetch FIFO with clear, occupancy count
//               and full/empty flags. DEPTH must be a power of two.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  wire                    clk,
    input  wire                    rst,
    input  wire                    push,
    input  wire                    pop,
    input  wire                    clear,
    input  wire fetch_entry_t      wr_data,
    output fetch_entry_t           rd_data,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] c_depth = (AW + 1)'(DEPTH);

    fetch_entry_t  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_do_push;
    logic          w_do_pop;

    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);

    assign full    = (r_count == c_depth);
    assign empty   = (r_count == '0);
    assign count   = r_count;
    assign rd_data = r_mem[r_rd_ptr];

    // Storage write; contents need no reset since occupancy gates visibility
    always_ff @(posedge clk) begin
        if (w_do_push && !clear) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    // Pointer and occupancy bookkeeping; clear discards everything
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + {{AW{1'b0}}, w_do_push} - {{AW{1'b0}}, w_do_pop};
        end
    end

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : Instruction-fetch stage. Owns the PC, keeps one request in
//               flight to instruction memory, buffers returned words in a
//               prefetch FIFO and flushes on redirect. Defining
//               FETCH_MISALIGN_TRAP_EN adds the fetch_misalign trap output.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
    parameter int          FIFO_DEPTH = 2
) (
    input  wire          clk,
    input  wire          rst,
    fetch_unit_if.master bus
);

    localparam int             CW      = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0]  c_depth = CW'(FIFO_DEPTH);

    fetch_state_t  r_state;
    fetch_state_t  w_state_next;
    logic [31:0]   r_fetch_pc;
    logic [31:0]   w_fetch_pc_next;
    logic [31:0]   r_hold_addr;
    logic [31:0]   w_target;
    logic          w_block;
    logic          w_push;
    logic          w_pop;
    logic          w_clear;
    logic          w_full;
    logic          w_empty;
    logic [CW-1:0] w_count;
    logic [CW-1:0] w_count_after;
    fetch_entry_t  w_head;
    fetch_entry_t  w_wr_entry;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic r_misalign;

    assign w_target            = {bus.target_pc[31:2], 2'b00};
    assign w_block             = r_misalign;
    assign bus.fetch_misalign  = r_misalign;

    // Trap flag follows the alignment of the most recent redirect
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_misalign <= 1'b0;
        end else if (bus.pc_sel) begin
            r_misalign <= |bus.target_pc[1:0];
        end
    end
`else
    logic w_unused_low_bits;

    assign w_unused_low_bits = |bus.target_pc[1:0];
    assign w_target          = {bus.target_pc[31:2], 2'b00};
    assign w_block           = 1'b0;
`endif

    // In REQ the PC register is the in-flight address; DROP holds the
    // abandoned address while fetch_pc already points at the new target.
    assign bus.imem_req  = (r_state != IDLE);
    assign bus.imem_addr = (r_state == DROP) ? r_hold_addr : r_fetch_pc;

    assign w_pop             = !w_empty && !bus.stall && !bus.pc_sel;
    assign w_count_after     = w_count + CW'(1) - {{(CW-1){1'b0}}, w_pop};
    assign w_wr_entry.instr  = bus.imem_rdata;
    assign w_wr_entry.pc     = bus.imem_addr;

    assign bus.instr_valid = !w_empty;
    assign bus.instr       = w_empty ? NOP_INSTR : w_head.instr;
    assign bus.instr_pc    = w_empty ? 32'h0000_0000 : w_head.pc;

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (w_push),
        .pop     (w_pop),
        .clear   (w_clear),
        .wr_data (w_wr_entry),
        .rd_data (w_head),
        .count   (w_count),
        .full    (w_full),
        .empty   (w_empty)
    );

    // Sequencer next state, PC update and FIFO control; redirect dominates
    always_comb begin
        w_state_next    = r_state;
        w_fetch_pc_next = r_fetch_pc;
        w_push          = 1'b0;
        w_clear         = 1'b0;
        case (r_state)
            IDLE: begin
                if (!bus.pc_sel && !w_full && !w_block) begin
                    w_state_next = REQ;
                end
            end
            REQ: begin
                if (bus.pc_sel) begin
                    w_state_next = bus.imem_ack ? IDLE : DROP;
                end else if (bus.imem_ack) begin
                    w_push          = 1'b1;
                    w_fetch_pc_next = r_fetch_pc + 32'd4;
                    w_state_next    = (w_count_after < c_depth) ? REQ : IDLE;
                end
            end
            DROP: begin
                if (bus.imem_ack) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
        if (bus.pc_sel) begin
            w_clear         = 1'b1;
            w_fetch_pc_next = w_target;
        end
    end

    // State, PC and abandoned-address registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_fetch_pc  <= RESET_PC;
            r_hold_addr <= RESET_PC;
        end else begin
            r_state    <= w_state_next;
            r_fetch_pc <= w_fetch_pc_next;
            if (r_state == REQ) begin
                r_hold_addr <= r_fetch_pc;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_unit
// Description : Self-checking bench for fetch_unit. Directed scenarios plus a
//               randomized run compared against a transaction-level model:
//               decode must see the program-order PC stream restarted at each
//               redirect target, with the memory word for each PC. Covers
//               fetch_misalign when FETCH_MISALIGN_TRAP_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;
    import fetch_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic rst2;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    fetch_unit_if bus();
    fetch_unit_if bus2();

    fetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) dut (
        .clk (clk), .rst (rst), .bus (bus)
    );
    fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(2)) dut_wrap (
        .clk (clk), .rst (rst2), .bus (bus2)
    );

    // Memory model and reference model state
    int          lat_min;
    int          lat_max;
    bit          mem_busy;
    int          mem_wait;
    int          m_count;     // words accepted and not yet delivered
    bit          m_taint;     // in-flight request predates a redirect
    bit          m_flag;      // misalign trap expected
    logic [31:0] m_pc;        // next PC decode must see
    bit          prev_hold;
    logic [31:0] prev_addr;
    int          delivered;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst            = 1'b1;
        bus.pc_sel     = 1'b0;
        bus.stall      = 1'b0;
        bus.imem_ack   = 1'b0;
        bus.target_pc  = 32'h0;
        bus.imem_rdata = 32'h0;
        @(negedge clk);
        #1;
        chk("rst_req",   bus.imem_req,    1'b0);
        chk("rst_addr",  bus.imem_addr,   32'h0);
        chk("rst_instr", bus.instr,       NOP_INSTR);
        chk("rst_pc",    bus.instr_pc,    32'h0);
        chk("rst_valid", bus.instr_valid, 1'b0);
`ifdef FETCH_MISALIGN_TRAP_EN
        chk("rst_misalign", bus.fetch_misalign, 1'b0);
`endif
        rst       = 1'b0;
        mem_busy  = 0;
        mem_wait  = 0;
        m_count   = 0;
        m_taint   = 0;
        m_flag    = 0;
        m_pc      = 32'h0;
        prev_hold = 0;
        prev_addr = 32'h0;
    endtask

    // One clock cycle: memory responds, inputs applied, outputs checked
    task automatic step(input logic sel, input logic [31:0] tgt, input logic stl);
        logic take;
        @(negedge clk);
        bus.imem_ack = 1'b0;
        if (bus.imem_req) begin
            if (!mem_busy) begin
                mem_busy = 1;
                mem_wait = $urandom_range(lat_max, lat_min);
            end
            if (mem_wait == 0) begin
                bus.imem_ack = 1'b1;
                mem_busy     = 0;
            end else begin
                mem_wait--;
            end
        end
        bus.imem_rdata = mem_word(bus.imem_addr);
        bus.pc_sel     = sel;
        bus.target_pc  = tgt;
        bus.stall      = stl;
        #1;
        if (prev_hold) begin
            chk("hold_req",  bus.imem_req,  1'b1);
            chk("hold_addr", bus.imem_addr, prev_addr);
        end
        if (!bus.instr_valid) begin
            chk("empty_instr", bus.instr,    NOP_INSTR);
            chk("empty_pc",    bus.instr_pc, 32'h0);
        end
        chk("valid", bus.instr_valid, m_count > 0);
        chk("occupancy", m_count <= 2, 1'b1);
`ifdef FETCH_MISALIGN_TRAP_EN
        chk("misalign", bus.fetch_misalign, m_flag);
        if (m_flag) chk("trap_no_req", bus.imem_req && !m_taint, 1'b0);
`endif
        take = bus.instr_valid && !stl && !sel;
        if (take) begin
            chk("pop_pc",    bus.instr_pc, m_pc);
            chk("pop_instr", bus.instr,    mem_word(m_pc));
            m_pc = m_pc + 32'd4;
            m_count--;
            delivered++;
        end
        if (bus.imem_req && bus.imem_ack) begin
            if (!sel && !m_taint) m_count++;
            m_taint = 0;
        end
        prev_hold = bus.imem_req && !bus.imem_ack;
        prev_addr = bus.imem_addr;
        if (sel) begin
            m_count = 0;
            m_taint = bus.imem_req && !bus.imem_ack;
            m_pc    = {tgt[31:2], 2'b00};
`ifdef FETCH_MISALIGN_TRAP_EN
            m_flag  = |tgt[1:0];
`endif
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int          n;
        logic [31:0] wexp [3];
        wexp = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};
        rst2 = 1'b1;
        bus2.imem_ack = 1'b1; bus2.imem_rdata = 32'h0;
        bus2.pc_sel = 1'b0; bus2.target_pc = 32'h0; bus2.stall = 1'b0;
        delivered = 0;
        lat_min = 0; lat_max = 0;

        // Single-cycle memory, no stall: one instruction per cycle
        do_reset();
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 32'h0, 1'b0);
            chk("seq_addr", bus.imem_addr, 32'(i * 4));
            if (i > 0) begin
                chk("seq_pc",    bus.instr_pc, 32'((i - 1) * 4));
                chk("seq_instr", bus.instr,    mem_word(32'((i - 1) * 4)));
            end
        end

        // Stall fills the buffer and stops requests; release resumes at 8
        do_reset();
        for (int i = 0; i < 5; i++) step(1'b0, 32'h0, 1'b1);
        chk("stall_req",  bus.imem_req, 1'b0);
        chk("stall_head", bus.instr_pc, 32'h0);
        step(1'b0, 32'h0, 1'b0);
        chk("rel_pc0", bus.instr_pc, 32'h0);
        step(1'b0, 32'h0, 1'b0);
        chk("rel_pc4", bus.instr_pc, 32'h4);
        step(1'b0, 32'h0, 1'b0);
        chk("resume_req",  bus.imem_req,  1'b1);
        chk("resume_addr", bus.imem_addr, 32'h8);

        // Slow memory: redirect while the fetch of 0x8 is in flight
        do_reset();
        lat_min = 3; lat_max = 3;
        n = 0;
        while (!(bus.imem_req && bus.imem_addr == 32'h8) && n < 40) begin
            step(1'b0, 32'h0, 1'b0);
            n++;
        end
        chk("reach_8", n < 40, 1'b1);
        step(1'b1, 32'h100, 1'b0);
        chk("drop_hold", bus.imem_addr, 32'h8);
        n = 0;
        while (!(bus.imem_req && bus.imem_addr == 32'h100) && n < 40) begin
            step(1'b0, 32'h0, 1'b0);
            chk("drop_novalid", bus.instr_valid, 1'b0);
            n++;
        end
        chk("reach_100", n < 40, 1'b1);
        n = 0;
        while (!bus.instr_valid && n < 40) begin
            step(1'b0, 32'h0, 1'b0);
            n++;
        end
        chk("first_pc_100", bus.instr_pc, 32'h100);

        // Redirect coinciding with the ack of 0x4
        do_reset();
        lat_min = 0; lat_max = 0;
        step(1'b0, 32'h0, 1'b0);
        chk("b_addr0", bus.imem_addr, 32'h0);
        step(1'b1, 32'h40, 1'b0);
        chk("b_addr4", bus.imem_addr, 32'h4);
        step(1'b0, 32'h0, 1'b0);
        chk("b_redir_addr", bus.imem_addr,   32'h40);
        chk("b_empty",      bus.instr_valid, 1'b0);
        step(1'b0, 32'h0, 1'b0);
        chk("b_req40", bus.imem_req, 1'b1);
        step(1'b0, 32'h0, 1'b0);
        chk("b_pc40", bus.instr_pc, 32'h40);

        // Address wrap from a high reset PC, then async reset mid-request
        @(negedge clk);
        rst2 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            chk("wrap_req",  bus2.imem_req,  1'b1);
            chk("wrap_addr", bus2.imem_addr, wexp[i]);
        end
        #2;
        rst2 = 1'b1;
        #1;
        chk("arst_req",   bus2.imem_req,    1'b0);
        chk("arst_instr", bus2.instr,       NOP_INSTR);
        chk("arst_valid", bus2.instr_valid, 1'b0);
        chk("arst_addr",  bus2.imem_addr,   32'hFFFF_FFF8);

`ifdef FETCH_MISALIGN_TRAP_EN
        // Misaligned redirect traps; aligned redirect recovers
        do_reset();
        step(1'b0, 32'h0, 1'b0);
        step(1'b0, 32'h0, 1'b0);
        step(1'b1, 32'h102, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 32'h0, 1'b0);
            chk("trap_flag", bus.fetch_misalign, 1'b1);
            chk("trap_req",  bus.imem_req,       1'b0);
        end
        step(1'b1, 32'h200, 1'b0);
        step(1'b0, 32'h0, 1'b0);
        chk("trap_clear", bus.fetch_misalign, 1'b0);
        step(1'b0, 32'h0, 1'b0);
        chk("trap_resume_req",  bus.imem_req,  1'b1);
        chk("trap_resume_addr", bus.imem_addr, 32'h200);
`endif

        // Randomized latency, stall and redirects against the model
        do_reset();
        lat_min = 0; lat_max = 3;
        delivered = 0;
        for (int i = 0; i < 3000; i++) begin
            logic        s;
            logic [31:0] t;
            s = ($urandom_range(99) < 4);
            t = $urandom & 32'h0000_0FFF;
            if ($urandom_range(3) != 0) t[1:0] = 2'b00;
            step(s, t, $urandom_range(99) < 30);
        end
        chk("progress", delivered > 300, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage directly upstream of decode: owns the PC, issues word requests to instruction memory over a req/ack handshake, and buffers returned words in a small prefetch FIFO.
- Presents {instr, instr_pc, instr_valid} to decode.
- Accepts redirects (pc_sel/target_pc) from branch/jump resolution and flushes stale fetches.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- FIFO_DEPTH, 2, prefetch buffer entries (power of 2, >=2).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- imem_req  out  1  fetch request valid.
- imem_addr  out  32  word-aligned fetch address.
- imem_ack  in  1  memory returns data this cycle; meaningful only while imem_req=1.
- imem_rdata  in  32  instruction word, valid with imem_ack.
- pc_sel  in  1  redirect strobe, one cycle.
- target_pc  in  32  redirect destination, sampled with pc_sel.
- stall  in  1  decode cannot accept an instruction this cycle.
- instr  out  32  head-of-FIFO instruction; 32'h0000_0013 (NOP) when empty.
- instr_pc  out  32  PC of instr; 0 when empty.
- instr_valid  out  1  FIFO non-empty.

Behaviour:
- Reset (async): fetch_pc=RESET_PC, FIFO empty, state=IDLE, imem_req=0, imem_addr=RESET_PC, instr=NOP, instr_pc=0, instr_valid=0.
- States:
  - IDLE: no request outstanding.
  - REQ: request outstanding.
  - DROP: request outstanding whose data must be discarded.
- IDLE->REQ: when FIFO has a free slot (count < FIFO_DEPTH) and no redirect this cycle. Assert imem_req, imem_addr=fetch_pc from the next edge.
- Hold rule: while in REQ/DROP, imem_req=1 and imem_addr stay stable until imem_ack. Exactly one request outstanding at a time.
- REQ + ack, no redirect:
  - Push {imem_rdata, imem_addr}; fetch_pc += 4 (mod 2^32, wraps 32'hFFFF_FFFC -> 0).
  - If space remains after this cycle's push/pop, issue the next request back-to-back (stay REQ, new address next cycle). Otherwise go to IDLE.
- Pop: occurs when instr_valid && !stall. Push and pop in the same cycle are allowed at full: count unchanged, and a back-to-back request is permitted.
- Redirect (pc_sel=1), highest priority:
  - FIFO cleared, no pop is counted, fetch_pc <= {target_pc[31:2],2'b00}.
  - If IDLE, or REQ with ack this cycle: data discarded; go IDLE, and the request to target issues the next cycle.
  - If REQ without ack: go DROP.
- DROP: on ack, discard data and go IDLE. A second redirect while in DROP updates fetch_pc only.
- Latency: redirect to first imem_req at target = 1 cycle (IDLE case). With a 1-cycle-ack memory and no stall, one instruction is delivered per cycle.
- instr/instr_pc are combinational from the FIFO head; no bubble insertion beyond empty=NOP.

Optional Feature:
- FETCH_MISALIGN_TRAP_EN
- Defined:
  - Adds output fetch_misalign (1 bit, reset 0).
  - A redirect with target_pc[1:0]!=0 sets fetch_misalign, clears the FIFO and blocks new requests (an outstanding one is still drained via DROP).
  - Cleared by an aligned redirect or reset.
- Undefined: port absent; target_pc[1:0] silently forced to 00.

Decomposition:
- Package fetch_pkg:
  - NOP_INSTR = 32'h0000_0013.
  - Fetch state enum {IDLE, REQ, DROP}.
  - Default RESET_PC.
  - FIFO entry typedef {instr[31:0], pc[31:0]}.
- Sub-module fetch_fifo:
  - Synchronous FIFO with push, pop, clear, count, full, empty.
  - Async active-high reset.
  - Parameter DEPTH.

Test Plan:
- Reset then 1-cycle-ack memory returning addr-derived words, stall=0: imem_addr sequence 0,4,8,12. instr_pc follows 0,4,8 one per cycle, and instr matches memory.
- stall=1 held for 5 cycles: exactly 2 entries buffered, imem_req drops to 0. Release stall: pops of PCs 0 then 4, and fetching resumes at 8 without a duplicate or a gap.
- Memory with 3-cycle ack latency, pc_sel with target_pc=32'h100 one cycle after req at 0x8: state DROP, ack data discarded (never valid). Next request has addr 0x100 and first instr_pc=0x100.
- pc_sel in the same cycle as an ack for 0x4 with target 0x40: 0x4 word not pushed, FIFO empty. imem_addr=0x40 the next cycle.
- RESET_PC=32'hFFFF_FFF8: addresses FFFF_FFF8, FFFF_FFFC, 0000_0000 (wrap). Asserting rst mid-request: imem_req=0, instr=NOP, instr_valid=0 immediately.
- With FETCH_MISALIGN_TRAP_EN: target 0x102 -> fetch_misalign=1, no requests issued. Redirect to 0x200 -> flag clears, fetch resumes at 0x200.
